aes_lite_arbiter: RTL

Arbiter and sequencer that shares one AES-lite byte-encryption engine between two requesters. Each requester offers a data/key byte pair on a valid/ready handshake. The block grants one job at a time, launches the engine with a one-cycle start pulse and waits for the engine's ready, with a timeout. It then returns the result to the requester, tagged with the requester ID and an error flag. It sits between the client ports and the engine's start/data/key/ready/data_out interface.

---
 rtl/aes_lite_arbiter_if.sv | 35 +++
 rtl/aes_lite_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/aes_lite_arbiter_if.sv
// Client, engine and response signals of the AES-lite arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface aes_lite_arbiter_if;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req0_data;
  logic [7:0] req0_key;
  logic [7:0] req1_data;
  logic [7:0] req1_key;
  logic       eng_start;
  logic [7:0] eng_data;
  logic [7:0] eng_key;
  logic       eng_ready;
  logic [7:0] eng_dout;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  modport slave (
    input  req_valid, req0_data, req0_key, req1_data, req1_key,
    input  eng_ready, eng_dout, rsp_ready,
    output req_ready, eng_start, eng_data, eng_key,
    output rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req0_data, req0_key, req1_data, req1_key,
    output eng_ready, eng_dout, rsp_ready,
    input  req_ready, eng_start, eng_data, eng_key,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/aes_lite_arbiter.sv
// Shares one AES-lite byte engine between two requesters with a timeout.
// Define AES_ARB_STRICT_PRIO_EN for fixed priority to requester 0 (default: round-robin).
module aes_lite_arbiter #(
  parameter int unsigned TIMEOUT = 31
) (
  input logic               clk,
  input logic               rst_n,
  aes_lite_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TIMEOUT_CYC = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] timer;
  logic       eng_start_q;
  logic [7:0] eng_data_q;
  logic [7:0] eng_key_q;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic [7:0] rsp_data_q;
  logic       rsp_err_q;
  logic       busy_q;
  logic       grant_id;
  logic       accept;
  logic [1:0] req_ready_c;

  // A held reset must never show a completed handshake to a requester.
  assign accept = rst_n && (state == S_IDLE) && (bus.req_valid != 2'b00);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    req_ready_c = 2'b00;
    if (accept) req_ready_c[grant_id] = 1'b1;
  end

`ifdef AES_ARB_STRICT_PRIO_EN
  // Requester 0 wins whenever it is valid.
  always_comb grant_id = ~bus.req_valid[0];
`else
  logic last_id;

  always_comb begin
    grant_id = 1'b0;
    case (bus.req_valid)
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_id;
      default: grant_id = 1'b0;
    endcase
  end

  // Fairness pointer moves only when a response is actually delivered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_id <= 1'b1;
    end else if (state == S_RESP && bus.rsp_ready) begin
      last_id <= rsp_id_q;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      timer       <= 8'h00;
      eng_start_q <= 1'b0;
      eng_data_q  <= 8'h00;
      eng_key_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      eng_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            eng_data_q  <= grant_id ? bus.req1_data : bus.req0_data;
            eng_key_q   <= grant_id ? bus.req1_key  : bus.req0_key;
            rsp_id_q    <= grant_id;
            eng_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= 8'h00;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving in the final timeout cycle still counts as success.
          if (bus.eng_ready) begin
            rsp_data_q  <= bus.eng_dout;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else if (timer == TIMEOUT_CYC) begin
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.eng_start = eng_start_q;
  assign bus.eng_data  = eng_data_q;
  assign bus.eng_key   = eng_key_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy_q;

endmodule
